// File: rtl/mmio_stress_if.sv
// MMIO request/response bundle between the stress initiator and an MMIO responder.
// Carries the c0 MMIO request fields and the c2 read-response fields.
interface mmio_stress_if #(
    parameter int ADDR_W = 16
);
    logic              mmio_wr_valid;
    logic              mmio_rd_valid;
    logic [ADDR_W-1:0] mmio_addr;
    logic [1:0]        mmio_len;
    logic [8:0]        mmio_tid;
    logic [63:0]       mmio_wdata;
    logic              rsp_valid;
    logic [8:0]        rsp_tid;
    logic [63:0]       rsp_data;

    modport master (
        output mmio_wr_valid, mmio_rd_valid, mmio_addr,
        output mmio_len, mmio_tid, mmio_wdata,
        input  rsp_valid, rsp_tid, rsp_data
    );

    modport slave (
        input  mmio_wr_valid, mmio_rd_valid, mmio_addr,
        input  mmio_len, mmio_tid, mmio_wdata,
        output rsp_valid, rsp_tid, rsp_data
    );
endinterface

// File: rtl/mmio_stress_initiator.sv
// MMIO stress initiator: LFSR-driven write + read-back pairs with response checking.
// Reports pass/fail, completed ops, mismatch count and first failing address.
module mmio_stress_initiator #(
    parameter int                NUM_OPS     = 1024,
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] ADDR_MIN    = 'h0008,
    parameter logic [ADDR_W-1:0] ADDR_MASK   = 'h00FF,
    parameter int                TIMEOUT     = 256,
    parameter int                IDLE_GAP    = 0,
    parameter bit                STOP_ON_ERR = 1'b0,
    parameter logic [63:0]       SEED        = 64'h1
) (
    input  logic              pClk,
    input  logic              pck_cp2af_softReset,
    input  logic              start,
    mmio_stress_if.master     bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [31:0]       op_count,
    output logic [15:0]       err_count,
    output logic              tid_err,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] fail_addr
);

    localparam logic [63:0] SEED_EFF = (SEED == 64'h0) ? 64'h1 : SEED;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_WR,
        S_RD,
        S_WAIT,
        S_GAP,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [63:0]       lfsr_q, lfsr_d;
    logic              wr_valid_q, wr_valid_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        len_q, len_d;
    logic [8:0]        tid_q, tid_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [31:0]       timer_q, timer_d;
    logic [31:0]       gap_q, gap_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [31:0]       op_count_q, op_count_d;
    logic [15:0]       err_count_q, err_count_d;
    logic              tid_err_q, tid_err_d;
    logic              timeout_err_q, timeout_err_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;

    logic [63:0]       lfsr_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic              data_ok;
    logic              last_op;

    // Fibonacci LFSR x^64+x^63+x^61+x^60+1, shifting toward the MSB.
    function automatic logic [63:0] lfsr_step(input logic [63:0] v);
        return {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
    endfunction

    // Next-state, request-field and status computation for the run FSM.
    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        wr_valid_d    = 1'b0;
        rd_valid_d    = 1'b0;
        addr_d        = addr_q;
        len_d         = len_q;
        tid_d         = tid_q;
        wdata_d       = wdata_q;
        timer_d       = timer_q;
        gap_d         = gap_q;
        busy_d        = busy_q;
        done_d        = done_q;
        pass_d        = pass_q;
        op_count_d    = op_count_q;
        err_count_d   = err_count_q;
        tid_err_d     = tid_err_q;
        timeout_err_d = timeout_err_q;
        fail_addr_d   = fail_addr_q;

        lfsr_nx = lfsr_step(lfsr_q);
        addr_nx = (lfsr_nx[ADDR_W:1] & ADDR_MASK) | ADDR_MIN;
        if (lfsr_nx[0]) begin
            addr_nx[0] = 1'b0;
        end

        // Short reads only check the low word; the upper half is don't-care.
        if (len_q == 2'b01) begin
            data_ok = (bus.rsp_data == wdata_q);
        end else begin
            data_ok = (bus.rsp_data[31:0] == wdata_q[31:0]);
        end
        last_op = ((op_count_q + 32'd1) == 32'(NUM_OPS));

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d        = 1'b1;
                    done_d        = 1'b0;
                    pass_d        = 1'b0;
                    op_count_d    = '0;
                    err_count_d   = '0;
                    tid_err_d     = 1'b0;
                    timeout_err_d = 1'b0;
                    fail_addr_d   = '0;
                    state_d       = S_GEN;
                end
            end
            S_GEN: begin
                lfsr_d     = lfsr_nx;
                len_d      = lfsr_nx[0] ? 2'b01 : 2'b00;
                addr_d     = addr_nx;
                wdata_d    = lfsr_nx;
                wr_valid_d = 1'b1;
                state_d    = S_WR;
            end
            S_WR: begin
                rd_valid_d = 1'b1;
                state_d    = S_RD;
            end
            S_RD: begin
                timer_d = 32'd1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 32'd1;
                if (bus.rsp_valid) begin
                    if (bus.rsp_tid == tid_q) begin
                        op_count_d = op_count_q + 32'd1;
                        tid_d      = tid_q + 9'd1;
                        gap_d      = '0;
                        if (!data_ok) begin
                            if (err_count_q != 16'hFFFF) begin
                                err_count_d = err_count_q + 16'd1;
                            end
                            if (err_count_q == 16'd0) begin
                                fail_addr_d = addr_q;
                            end
                        end
                        if (last_op || (!data_ok && STOP_ON_ERR)) begin
                            state_d = S_FIN;
                        end else if (IDLE_GAP > 0) begin
                            state_d = S_GAP;
                        end else begin
                            state_d = S_GEN;
                        end
                    end else begin
                        tid_err_d = 1'b1;
                        if (STOP_ON_ERR) begin
                            tid_d   = tid_q + 9'd1;
                            state_d = S_FIN;
                        end
                    end
                end
                // Timeout is judged only if the response did not end the wait.
                if (state_d == S_WAIT && timer_q >= 32'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    tid_d         = tid_q + 9'd1;
                    state_d       = S_FIN;
                end
            end
            S_GAP: begin
                if (gap_q >= 32'(IDLE_GAP - 1)) begin
                    state_d = S_GEN;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_count_q == 16'd0) && !tid_err_q &&
                          !timeout_err_q && (op_count_q == 32'(NUM_OPS));
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any outstanding read.
    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            state_q       <= S_IDLE;
            lfsr_q        <= SEED_EFF;
            wr_valid_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            tid_q         <= '0;
            wdata_q       <= '0;
            timer_q       <= '0;
            gap_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            op_count_q    <= '0;
            err_count_q   <= '0;
            tid_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            fail_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            wr_valid_q    <= wr_valid_d;
            rd_valid_q    <= rd_valid_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            tid_q         <= tid_d;
            wdata_q       <= wdata_d;
            timer_q       <= timer_d;
            gap_q         <= gap_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            op_count_q    <= op_count_d;
            err_count_q   <= err_count_d;
            tid_err_q     <= tid_err_d;
            timeout_err_q <= timeout_err_d;
            fail_addr_q   <= fail_addr_d;
        end
    end

    assign bus.mmio_wr_valid = wr_valid_q;
    assign bus.mmio_rd_valid = rd_valid_q;
    assign bus.mmio_addr     = addr_q;
    assign bus.mmio_len      = len_q;
    assign bus.mmio_tid      = tid_q;
    assign bus.mmio_wdata    = wdata_q;

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign op_count    = op_count_q;
    assign err_count   = err_count_q;
    assign tid_err     = tid_err_q;
    assign timeout_err = timeout_err_q;
    assign fail_addr   = fail_addr_q;

endmodule

// File: tb/tb_mmio_stress_initiator.sv
// Directed bench for mmio_stress_initiator with a negedge-driven MMIO responder.
// Expected addresses/data are hand-derived from the LFSR seed used below.
module tb_mmio_stress_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, pass, tid_err, timeout_err;
    logic [31:0] op_count;
    logic [15:0] err_count;
    logic [15:0] fail_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mmio_stress_if #(.ADDR_W(16)) bus ();

    mmio_stress_initiator #(
        .NUM_OPS    (4),
        .ADDR_W     (16),
        .TIMEOUT    (16),
        .IDLE_GAP   (0),
        .STOP_ON_ERR(1'b0),
        .SEED       (64'h8000_0001_0000_0001)
    ) dut (
        .pClk               (clk),
        .pck_cp2af_softReset(rst),
        .start              (start),
        .bus                (bus),
        .busy               (busy),
        .done               (done),
        .pass               (pass),
        .op_count           (op_count),
        .err_count          (err_count),
        .tid_err            (tid_err),
        .timeout_err        (timeout_err),
        .fail_addr          (fail_addr)
    );

    // Responder modes: 0 echo, 1 silent, 2 flip bit0 on read 3,
    // 3 garbage upper word, 4 wrong tid once then correct.
    int          mode = 0;
    logic        pend = 1'b0;
    logic [8:0]  ptid = '0;
    logic [63:0] cap  = '0;
    int          rd_idx = 0;
    bit          bad_once = 1'b0;
    logic [15:0] wa_q[$];
    logic [1:0]  wl_q[$];
    logic [63:0] wd_q[$];
    logic [15:0] ra_q[$];
    logic [8:0]  rt_q[$];

    always @(negedge clk) begin
        if (bus.mmio_wr_valid) begin
            cap = bus.mmio_wdata;
            wa_q.push_back(bus.mmio_addr);
            wl_q.push_back(bus.mmio_len);
            wd_q.push_back(bus.mmio_wdata);
        end
        if (bus.mmio_rd_valid) begin
            ra_q.push_back(bus.mmio_addr);
            rt_q.push_back(bus.mmio_tid);
        end
        if (mode != 1) begin
            bus.rsp_valid = 1'b0;
            if (pend) begin
                bus.rsp_valid = 1'b1;
                bus.rsp_tid   = ptid;
                bus.rsp_data  = cap;
                if (mode == 2 && rd_idx == 3) begin
                    bus.rsp_data[0] = ~cap[0];
                end
                if (mode == 3) begin
                    bus.rsp_data[63:32] = 32'hDEADBEEF;
                end
                pend = 1'b0;
                if (mode == 4 && bad_once) begin
                    bus.rsp_tid = ptid + 9'd1;
                    bad_once    = 1'b0;
                    pend        = 1'b1;
                end
            end
            if (bus.mmio_rd_valid) begin
                pend   = 1'b1;
                ptid   = bus.mmio_tid;
                rd_idx = rd_idx + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_run();
        wa_q.delete(); wl_q.delete(); wd_q.delete();
        ra_q.delete(); rt_q.delete();
        rd_idx = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {63'd0, done}, 64'd1);
    endtask

    task automatic wait_rd(input string tag);
        int n = 0;
        while (!bus.mmio_rd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {63'd0, bus.mmio_rd_valid}, 64'd1);
    endtask

    logic [8:0] t6tid;
    int         k;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_tid = '0;
        bus.rsp_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_status", {59'd0, busy, done, pass, tid_err, timeout_err}, 64'd0);
        chk("rst_counts", {16'd0, op_count, err_count}, 64'd0);
        chk("rst_bus", {52'd0, bus.mmio_wr_valid, bus.mmio_rd_valid,
                        bus.mmio_len, bus.mmio_tid}, 64'd0);
        chk("rst_addr", {48'd0, bus.mmio_addr}, 64'd0);

        // 1: clean run; a second start mid-run must be ignored
        mode = 0;
        start_run();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t1_done");
        chk("t1_pass", {63'd0, pass}, 64'd1);
        chk("t1_ops", {32'd0, op_count}, 64'd4);
        chk("t1_nwr", 64'(wa_q.size()), 64'd4);
        chk("t1_a0", {48'd0, wa_q[0]}, 64'h8);
        chk("t1_l0", {62'd0, wl_q[0]}, 64'd1);
        chk("t1_d0", wd_q[0], 64'h0000_0002_0000_0003);
        chk("t1_a1", {48'd0, wa_q[1]}, 64'hB);
        chk("t1_a2", {48'd0, wa_q[2]}, 64'hE);
        chk("t1_a3", {48'd0, wa_q[3]}, 64'hC);
        chk("t1_l1", {62'd0, wl_q[1]}, 64'd0);
        chk("t1_ra0", {48'd0, ra_q[0]}, 64'h8);
        chk("t1_tid0", {55'd0, rt_q[0]}, 64'd0);
        chk("t1_tid3", {55'd0, rt_q[3]}, 64'd3);

        // 2: data corruption on op 3
        mode = 2;
        start_run();
        wait_done("t2_done");
        chk("t2_err", {48'd0, err_count}, 64'd1);
        chk("t2_faddr", {48'd0, fail_addr}, 64'h68);
        chk("t2_pass", {63'd0, pass}, 64'd0);
        chk("t2_ops", {32'd0, op_count}, 64'd4);
        chk("t2_a0", {48'd0, wa_q[0]}, 64'h18);

        // 3: garbage upper word on 32-bit ops is not an error
        mode = 3;
        start_run();
        wait_done("t3_done");
        chk("t3_len", {62'd0, wl_q[0]}, 64'd0);
        chk("t3_a0", {48'd0, wa_q[0]}, 64'h88);
        chk("t3_err", {48'd0, err_count}, 64'd0);
        chk("t3_pass", {63'd0, pass}, 64'd1);

        // 4: silent responder times out 16 cycles after the read
        mode = 1;
        start_run();
        wait_rd("t4_rd");
        k = 0;
        while (!timeout_err && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t4_lat", 64'(k), 64'd16);
        wait_done("t4_done");
        chk("t4_to", {63'd0, timeout_err}, 64'd1);
        chk("t4_pass", {63'd0, pass}, 64'd0);
        chk("t4_ops", {32'd0, op_count}, 64'd0);

        // 5: one wrong-tid response, then the right one
        mode = 4;
        bad_once = 1'b1;
        start_run();
        wait_done("t5_done");
        chk("t5_tiderr", {63'd0, tid_err}, 64'd1);
        chk("t5_to", {63'd0, timeout_err}, 64'd0);
        chk("t5_ops", {32'd0, op_count}, 64'd4);
        chk("t5_err", {48'd0, err_count}, 64'd0);
        chk("t5_pass", {63'd0, pass}, 64'd0);
        chk("t5_tid0", {55'd0, rt_q[0]}, 64'd13);

        // 6: reset while waiting, late response afterwards
        mode = 1;
        start_run();
        wait_rd("t6_rd");
        @(negedge clk);
        @(negedge clk);
        t6tid = bus.mmio_tid;
        chk("t6_tid", {55'd0, t6tid}, 64'd17);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.rsp_valid = 1'b1;
        bus.rsp_tid = t6tid;
        bus.rsp_data = cap;
        @(negedge clk);
        bus.rsp_valid = 1'b0;
        @(negedge clk);
        chk("t6_status", {59'd0, busy, done, pass, tid_err, timeout_err}, 64'd0);
        chk("t6_counts", {16'd0, op_count, err_count}, 64'd0);
        chk("t6_bus", {52'd0, bus.mmio_wr_valid, bus.mmio_rd_valid,
                       bus.mmio_len, bus.mmio_tid}, 64'd0);
        chk("t6_addr", {32'd0, bus.mmio_addr, fail_addr}, 64'd0);

        mode = 0;
        start_run();
        wait_done("t6b_done");
        chk("t6b_pass", {63'd0, pass}, 64'd1);
        chk("t6b_a0", {48'd0, wa_q[0]}, 64'h8);
        chk("t6b_d0", wd_q[0], 64'h0000_0002_0000_0003);
        chk("t6b_a1", {48'd0, wa_q[1]}, 64'hB);
        chk("t6b_a2", {48'd0, wa_q[2]}, 64'hE);
        chk("t6b_a3", {48'd0, wa_q[3]}, 64'hC);
        chk("t6b_tid0", {55'd0, rt_q[0]}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
